// File: rtl/cursor_sprite_overlay_pkg.sv
// Shared types for the cursor overlay: VGA and mouse buses, sprite codes, clamp helper.
// Pure declarations; no timing or flow control.
package cursor_sprite_overlay_pkg;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    logic [11:0] xpos;
    logic [11:0] ypos;
  } mouse_t;

  localparam int VGA_BUS_SIZE   = $bits(vga_t);
  localparam int MOUSE_BUS_SIZE = $bits(mouse_t);

  typedef enum logic [1:0] {
    CODE_TRANSP  = 2'd0,
    CODE_OUTLINE = 2'd1,
    CODE_FILL    = 2'd2,
    CODE_ACCENT  = 2'd3
  } sprite_code_t;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/cursor_sprite_overlay_if.sv
// VGA bus wrapper; master drives the bus, slave observes it.
// No handshake: one pixel per cycle, no backpressure.
interface cursor_sprite_overlay_if;
  cursor_sprite_overlay_pkg::vga_t bus;

  modport master (output bus);
  modport slave  (input  bus);
endinterface

// File: rtl/cursor_sprite_overlay_rom.sv
// Arrow cursor bitmap, 2 bits per pixel, addressed row*SPRITE_W+col.
// Combinational lookup, zero latency, no backpressure.
module cursor_sprite_rom
  import cursor_sprite_overlay_pkg::*;
#(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int AW       = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic [AW-1:0] addr,
  output sprite_code_t  code
);

  int row;
  int col;

  always_comb begin
    row  = int'(addr) / SPRITE_W;
    col  = int'(addr) % SPRITE_W;
    code = CODE_TRANSP;
    if (row < SPRITE_H) begin
      // Triangle head with outlined edges, a base line, then a two-wide accented stem.
      if (row <= 10) begin
        if (col == 0 || col == row) code = CODE_OUTLINE;
        else if (col < row)         code = CODE_FILL;
      end else if (row == 11) begin
        if (col <= 5) code = CODE_OUTLINE;
      end else if (row <= 14) begin
        if (col == 4 || col == 7)      code = CODE_OUTLINE;
        else if (col == 5 || col == 6) code = CODE_ACCENT;
      end else if (row == 15) begin
        if (col >= 4 && col <= 7) code = CODE_OUTLINE;
      end
    end
  end

endmodule

// File: rtl/cursor_sprite_overlay.sv
// Overlays a scaled 2bpp cursor sprite at the frame-latched mouse position onto the VGA bus.
// Fixed 2-cycle latency on every field; one pixel per cycle, never stalls.
module cursor_sprite_overlay
  import cursor_sprite_overlay_pkg::*;
#(
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter int          SCALE_LOG2  = 0,
  parameter int          HOT_X       = 0,
  parameter int          HOT_Y       = 0,
  parameter int          H_ACTIVE    = 800,
  parameter int          V_ACTIVE    = 600,
  parameter logic [11:0] COL_OUTLINE = 12'h000,
  parameter logic [11:0] COL_FILL    = 12'hFFF,
  parameter logic [11:0] COL_PRESS   = 12'hF00,
  parameter logic [11:0] COL_ACCENT  = 12'h888
) (
  input  logic                           pclk,
  input  logic                           rst_n,
  input  mouse_t                         mouse_in,
  input  logic                           btn_left,
  cursor_sprite_overlay_if.slave         vga_in,
  cursor_sprite_overlay_if.master        vga_out
);

  localparam int AW = $clog2(SPRITE_W * SPRITE_H);
  localparam logic signed [12:0] OFF_X  = 13'(HOT_X << SCALE_LOG2);
  localparam logic signed [12:0] OFF_Y  = 13'(HOT_Y << SCALE_LOG2);
  localparam logic signed [12:0] SPAN_X = 13'(SPRITE_W << SCALE_LOG2);
  localparam logic signed [12:0] SPAN_Y = 13'(SPRITE_H << SCALE_LOG2);
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1);

  vga_t in_bus;
  assign in_bus = vga_in.bus;

  logic [11:0] x_lat;
  logic [11:0] y_lat;
  logic        pressed;
  logic        vblnk_prev;

  // Position and button are sampled only on the vblank rising edge so a frame never tears.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat      <= '0;
      y_lat      <= '0;
      pressed    <= 1'b0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= in_bus.vblnk;
      if (in_bus.vblnk && !vblnk_prev) begin
        x_lat   <= clamp12(mouse_in.xpos, X_MAX);
        y_lat   <= clamp12(mouse_in.ypos, Y_MAX);
        pressed <= btn_left;
      end
    end
  end

  logic signed [12:0] ox, oy, dx, dy;
  logic [12:0]        col_c, row_c;
  logic [AW-1:0]      addr_c;
  logic               hit_c;

  always_comb begin
    ox     = $signed({1'b0, x_lat}) - OFF_X;
    oy     = $signed({1'b0, y_lat}) - OFF_Y;
    dx     = $signed({2'b00, in_bus.hcount}) - ox;
    dy     = $signed({2'b00, in_bus.vcount}) - oy;
    hit_c  = !dx[12] && (dx < SPAN_X) && !dy[12] && (dy < SPAN_Y)
             && !in_bus.hblnk && !in_bus.vblnk;
    col_c  = dx >>> SCALE_LOG2;
    row_c  = dy >>> SCALE_LOG2;
    addr_c = AW'(row_c * 13'(SPRITE_W) + col_c);
  end

  vga_t          s1_bus;
  logic          s1_hit;
  logic          s1_pressed;
  logic [AW-1:0] s1_addr;

  // The press state travels with the pixel so the colour matches the origin it was hit against.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_bus     <= '0;
      s1_hit     <= 1'b0;
      s1_pressed <= 1'b0;
      s1_addr    <= '0;
    end else begin
      s1_bus     <= in_bus;
      s1_hit     <= hit_c;
      s1_pressed <= pressed;
      s1_addr    <= addr_c;
    end
  end

  sprite_code_t code;

  cursor_sprite_rom #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .AW       (AW)
  ) u_rom (
    .addr (s1_addr),
    .code (code)
  );

  vga_t out_c;

  always_comb begin
    out_c = s1_bus;
    if (s1_hit) begin
      unique case (code)
        CODE_TRANSP:  ;
        CODE_OUTLINE: out_c.rgb = COL_OUTLINE;
        CODE_FILL:    out_c.rgb = s1_pressed ? COL_PRESS : COL_FILL;
        CODE_ACCENT:  out_c.rgb = COL_ACCENT;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) vga_out.bus <= '0;
    else        vga_out.bus <= out_c;
  end

endmodule
